// File: rtl/rotate_req_scheduler.sv
// ---------------------------------------------------------------------------
// rotate_req_scheduler
//
// Lets NUM_REQ requesters share one pipelined rotate-left barrel shifter that
// sits outside this block. Each cycle a round-robin arbiter picks at most one
// requester and sends its operand and rotate amount to the shifter. A tag
// pipeline of {valid, id} moves in lockstep with the shifter, so each shifter
// output can be matched to the requester that issued it. Results wait in a
// first-word-fall-through response FIFO. A credit counter limits the number of
// in-flight plus buffered operations to FIFO_DEPTH, so a stalled consumer can
// never cause a shifter result to be dropped.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-high
//   req_valid       : [NUM_REQ]            per-requester request valid
//   req_ready       : [NUM_REQ]            per-requester accept, one-hot or zero
//   req_data        : [NUM_REQ*DATA_WIDTH] operands, requester i at slice i
//   req_amount      : [NUM_REQ*SA_W]       rotate amounts, requester i at slice i
//   sh_data_in      : [DATA_WIDTH]         to shifter data_in (0 when idle)
//   sh_shift_amount : [SA_W]               to shifter shift_amount (0 when idle)
//   sh_data_out     : [DATA_WIDTH]         from shifter data_out
//   rsp_valid       : response available (FIFO not empty)
//   rsp_ready       : downstream accepts the response
//   rsp_data        : [DATA_WIDTH]         rotated result at the FIFO head
//   rsp_id          : [ID_W]               originating requester of that result
// ---------------------------------------------------------------------------
module rotate_req_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 1,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int SA_W = ($clog2(DATA_WIDTH) > 1) ? $clog2(DATA_WIDTH) : 1,
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*SA_W-1:0]       req_amount,
  output logic [DATA_WIDTH-1:0]         sh_data_in,
  output logic [SA_W-1:0]               sh_shift_amount,
  input  logic [DATA_WIDTH-1:0]         sh_data_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id
);

  // A shifter depth of 0 is treated as a single stage.
  localparam int S     = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Arbitration and credit state
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;

  // Tag pipeline that runs alongside the shifter
  logic [S-1:0]           tag_valid_q, tag_valid_d;
  logic [S-1:0][ID_W-1:0] tag_id_q, tag_id_d;

  // Response FIFO
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [FIFO_DEPTH-1:0][ID_W-1:0]       fifo_id_q, fifo_id_d;
  logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                      fifo_cnt_q, fifo_cnt_d;

  // Combinational helpers
  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [DATA_WIDTH-1:0] win_data;
  logic [SA_W-1:0]       win_amount;
  logic                  credit_avail;
  logic                  issue;
  logic                  fifo_push;
  logic                  fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting just after last_grant. The first loop finds
  // the lowest valid index above the pointer. If it finds none, the second
  // loop wraps around and takes the lowest valid index at or below the pointer.
  // This gives the order last_grant+1, +2, ... modulo NUM_REQ without any
  // modulo arithmetic. With NUM_REQ=1, the second loop alone selects the
  // single requester.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    win_data   = '0;
    win_amount = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid[j] && (ID_W'(j) > last_grant_q)) begin
        win_found  = 1'b1;
        win_id     = ID_W'(j);
        win_data   = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        win_amount = req_amount[j*SA_W +: SA_W];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid[j] && (ID_W'(j) <= last_grant_q)) begin
        win_found  = 1'b1;
        win_id     = ID_W'(j);
        win_data   = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        win_amount = req_amount[j*SA_W +: SA_W];
      end
    end
  end

  // Issue happens only when a credit is free. A pop in the same cycle does not
  // free a credit. Issue is also held off while reset is asserted. Otherwise a
  // requester could see an accept for an operation whose tag the reset is about
  // to clear, and that operation would be lost without notice.
  always_comb begin
    credit_avail    = (credit_cnt_q < DEPTH_CNT);
    issue           = win_found && credit_avail && !reset;
    req_ready       = '0;
    sh_data_in      = '0;
    sh_shift_amount = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (issue && (win_id == ID_W'(j))) begin
        req_ready[j] = 1'b1;
      end
    end
    if (issue) begin
      sh_data_in      = win_data;
      sh_shift_amount = win_amount;
    end
  end

  // The pointer moves to the winner only when an operation is actually issued.
  // A requester that wins but is blocked by credits keeps its priority.
  // Credits count operations in the shifter plus entries in the FIFO.
  always_comb begin
    last_grant_d = issue ? win_id : last_grant_q;
    credit_cnt_d = credit_cnt_q;
    unique case ({issue, fifo_pop})
      2'b10:   credit_cnt_d = credit_cnt_q + 1'b1;
      2'b01:   credit_cnt_d = credit_cnt_q - 1'b1;
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  // The tag pipeline advances every cycle, with no stall, exactly like the
  // shifter. Stage 0 captures this cycle's issue and winner. The last stage
  // lines up with sh_data_out.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = issue;
    tag_id_d[0]    = win_id;
    for (int i = 1; i < S; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end
  end

  // FWFT response FIFO. A push from the last tag stage becomes visible one
  // cycle later, because there is no bypass around the storage. Push and pop
  // in the same cycle are both performed. The head outputs are forced to zero
  // while the FIFO is empty, so the storage itself needs no reset.
  always_comb begin
    fifo_push   = tag_valid_q[S-1];
    rsp_valid   = (fifo_cnt_q != '0);
    fifo_pop    = rsp_valid && rsp_ready;
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (fifo_push) begin
      fifo_data_d[wr_ptr_q] = sh_data_out;
      fifo_id_d[wr_ptr_q]   = tag_id_q[S-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (fifo_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    rsp_id   = rsp_valid ? fifo_id_q[rd_ptr_q] : '0;
  end

  // Control state. Reset discards everything in flight. Clearing the credit
  // count returns all of those credits, and the pointer is set so that
  // requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LAST_ID;
      credit_cnt_q <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      credit_cnt_q <= credit_cnt_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // FIFO storage is not reset. Its contents are only visible while the count
  // says they are valid.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_id_q   <= fifo_id_d;
  end

  // The credit scheme guarantees that a capture never finds the FIFO full and
  // that a pop never happens with no credit outstanding. If either occurs, the
  // accounting is broken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_push && (fifo_cnt_q == DEPTH_CNT)));
      assert (!(fifo_pop && (credit_cnt_q == '0)));
    end
  end

endmodule
